// File: rtl/shader_program_scheduler.sv
// Stages one complete shader program from the SPI receiver and commits it to
// shader memory only inside a fresh vertical-blank window.
module shader_program_scheduler #(
   parameter int NUM_INSTR = 10,
   parameter int INSTR_W   = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               wr_valid_i,
   input  logic [INSTR_W-1:0] wr_data_i,
   output logic               wr_ready_o,
   input  logic               flush_i,
   input  logic               window_i,
   output logic               mem_load_o,
   output logic               mem_shift_o,
   output logic [INSTR_W-1:0] mem_instr_o,
   output logic               mem_own_o,
   output logic               pending_o,
   output logic               commit_done_o,
   output logic               overrun_o
);

   localparam int PTR_W = $clog2(NUM_INSTR);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_INSTR - 1);
   localparam logic [PTR_W-1:0] ZERO_PTR = PTR_W'(0);
   localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);

   typedef enum logic [1:0] {
      S_COLLECT = 2'd0,
      S_PENDING = 2'd1,
      S_COMMIT  = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic               win_q;
   logic               overrun_q, overrun_d;
   logic [INSTR_W-1:0] stage_q [NUM_INSTR];
   logic               wr_accept_s;
   logic               win_rise_s;
   logic               win_fall_s;

   assign wr_accept_s = wr_valid_i && wr_ready_o;
   assign win_rise_s  = !win_q && window_i;
   assign win_fall_s  = win_q && !window_i;

   // Flush wins over a same-cycle write so the offered byte is dropped.
   assign wr_ready_o    = (state_q == S_COLLECT) && !flush_i;
   assign pending_o     = (state_q == S_PENDING) || (state_q == S_COMMIT);
   assign mem_own_o     = (state_q == S_COMMIT);
   assign mem_load_o    = mem_own_o;
   assign mem_shift_o   = mem_own_o;
   assign mem_instr_o   = mem_own_o ? stage_q[rd_ptr_q] : {INSTR_W{1'b0}};
   assign commit_done_o = (state_q == S_DONE);
   assign overrun_o     = overrun_q;

   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      overrun_d = overrun_q;
      case (state_q)
         S_COLLECT: begin
            if (flush_i) begin
               wr_ptr_d = ZERO_PTR;
            end else if (wr_accept_s) begin
               if (wr_ptr_q == LAST_PTR) begin
                  wr_ptr_d = ZERO_PTR;
                  state_d  = S_PENDING;
               end else begin
                  wr_ptr_d = wr_ptr_q + ONE_PTR;
               end
            end else begin
               wr_ptr_d = wr_ptr_q;
            end
         end
         S_PENDING: begin
            // Only a genuine rising edge starts a commit, never mid-window.
            if (flush_i) begin
               wr_ptr_d = ZERO_PTR;
               state_d  = S_COLLECT;
            end else if (win_rise_s) begin
               rd_ptr_d = ZERO_PTR;
               state_d  = S_COMMIT;
            end else begin
               state_d = S_PENDING;
            end
         end
         S_COMMIT: begin
            if (rd_ptr_q == LAST_PTR) begin
               rd_ptr_d = ZERO_PTR;
               state_d  = S_DONE;
            end else begin
               rd_ptr_d = rd_ptr_q + ONE_PTR;
            end
            if (win_fall_s) begin
               overrun_d = 1'b1;
            end else begin
               overrun_d = overrun_q;
            end
         end
         S_DONE: begin
            state_d = S_COLLECT;
         end
         default: begin
            state_d  = S_COLLECT;
            wr_ptr_d = ZERO_PTR;
            rd_ptr_d = ZERO_PTR;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_COLLECT;
         wr_ptr_q  <= ZERO_PTR;
         rd_ptr_q  <= ZERO_PTR;
         win_q     <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         win_q     <= window_i;
         overrun_q <= overrun_d;
      end
   end

   // Staging array holds data only; validity is tracked by the FSM.
   always_ff @(posedge clk_i) begin
      if (wr_accept_s) begin
         stage_q[wr_ptr_q] <= wr_data_i;
      end
   end

endmodule

// File: tb/tb_shader_program_scheduler.sv
// Scoreboard bench: staged bytes expected to commit are queued, and a monitor
// pops and compares them whenever the scheduler strobes the shader memory.
module tb_shader_program_scheduler;

   logic       clk;
   logic       rst;
   logic       wr_valid;
   logic [7:0] wr_data;
   logic       wr_ready;
   logic       flush;
   logic       window;
   logic       mem_load;
   logic       mem_shift;
   logic [7:0] mem_instr;
   logic       mem_own;
   logic       pending;
   logic       commit_done;
   logic       overrun;

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int load_cnt = 0;
   int done_cnt = 0;
   logic [7:0] exp_q [$];

   shader_program_scheduler #(.NUM_INSTR(10), .INSTR_W(8)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .wr_valid_i    (wr_valid),
      .wr_data_i     (wr_data),
      .wr_ready_o    (wr_ready),
      .flush_i       (flush),
      .window_i      (window),
      .mem_load_o    (mem_load),
      .mem_shift_o   (mem_shift),
      .mem_instr_o   (mem_instr),
      .mem_own_o     (mem_own),
      .pending_o     (pending),
      .commit_done_o (commit_done),
      .overrun_o     (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic stage(input logic [7:0] base, input int n, input bit push);
      for (int i = 0; i < n; i++) begin
         wr_valid = 1'b1;
         wr_data  = base + 8'(i);
         if (push) exp_q.push_back(base + 8'(i));
         tick();
      end
      wr_valid = 1'b0;
   endtask

   // Monitor: every load strobe must match the next queued instruction.
   always @(negedge clk) begin
      if (commit_done === 1'b1) done_cnt++;
      if (mem_load === 1'b1) begin
         load_cnt++;
         chk("mem_shift", {31'd0, mem_shift}, 32'd1);
         chk("mem_own", {31'd0, mem_own}, 32'd1);
         if (exp_q.size() == 0) begin
            chk("unexpected_load", 32'd1, 32'd0);
         end else begin
            chk("mem_instr", {24'd0, mem_instr}, {24'd0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      int l0;
      int d0;
      rst = 1'b1; wr_valid = 1'b0; wr_data = 8'h00; flush = 1'b0; window = 1'b0;
      tick(); tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
      chk("rst_pending", {31'd0, pending}, 32'd0);
      chk("rst_mem_load", {31'd0, mem_load}, 32'd0);
      chk("rst_mem_instr", {24'd0, mem_instr}, 32'd0);
      chk("rst_overrun", {31'd0, overrun}, 32'd0);
      chk("rst_done", {31'd0, commit_done}, 32'd0);
      tick();

      // Stage 0x10..0x19 with window low: buffer fills, nothing commits.
      stage(8'h10, 10, 1'b1);
      @(negedge clk);
      chk("t1_wr_ready", {31'd0, wr_ready}, 32'd0);
      chk("t1_pending", {31'd0, pending}, 32'd1);
      chk("t1_no_load", load_cnt, 32'd0);
      tick();

      // Open window: one-cycle latency, exactly 10 loads, one done pulse.
      window = 1'b1;
      @(negedge clk);
      chk("t2_latency_no_load", {31'd0, mem_load}, 32'd0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t2_load_high", {31'd0, mem_load}, 32'd1);
         chk("t2_pending_high", {31'd0, pending}, 32'd1);
      end
      @(negedge clk);
      chk("t2_done", {31'd0, commit_done}, 32'd1);
      chk("t2_done_no_load", {31'd0, mem_load}, 32'd0);
      chk("t2_done_pending", {31'd0, pending}, 32'd0);
      chk("t2_instr_zero", {24'd0, mem_instr}, 32'd0);
      @(negedge clk);
      chk("t2_done_once", {31'd0, commit_done}, 32'd0);
      chk("t2_wr_ready", {31'd0, wr_ready}, 32'd1);
      chk("t2_load_cnt", load_cnt, 32'd10);
      chk("t2_overrun", {31'd0, overrun}, 32'd0);
      repeat (36) tick();
      window = 1'b0;
      tick();

      // Stage while the window is already high: must wait for a new rise.
      window = 1'b1;
      tick(); tick();
      l0 = load_cnt; d0 = done_cnt;
      stage(8'h30, 10, 1'b1);
      repeat (6) tick();
      chk("t3_no_commit", load_cnt - l0, 32'd0);
      chk("t3_pending", {31'd0, pending}, 32'd1);
      window = 1'b0;
      tick();
      window = 1'b1;
      repeat (14) tick();
      chk("t3_load_cnt", load_cnt - l0, 32'd10);
      chk("t3_done_cnt", done_cnt - d0, 32'd1);
      window = 1'b0;
      tick();

      // Partial program, flush (with a byte offered alongside), fresh program.
      stage(8'h55, 4, 1'b0);
      flush = 1'b1; wr_valid = 1'b1; wr_data = 8'h99;
      @(negedge clk);
      chk("t4_flush_ready", {31'd0, wr_ready}, 32'd0);
      tick();
      flush = 1'b0; wr_valid = 1'b0;
      l0 = load_cnt; d0 = done_cnt;
      stage(8'hA0, 10, 1'b1);
      @(negedge clk);
      chk("t4_pending", {31'd0, pending}, 32'd1);
      tick();
      window = 1'b1;
      repeat (14) tick();
      chk("t4_load_cnt", load_cnt - l0, 32'd10);
      chk("t4_done_cnt", done_cnt - d0, 32'd1);
      chk("t4_queue_empty", exp_q.size(), 32'd0);
      window = 1'b0;
      tick();

      // Window falls after 5 commit cycles: commit completes, overrun sticks.
      l0 = load_cnt;
      stage(8'hC0, 10, 1'b1);
      window = 1'b1;
      repeat (6) tick();
      window = 1'b0;
      repeat (10) tick();
      chk("t5_load_cnt", load_cnt - l0, 32'd10);
      chk("t5_overrun", {31'd0, overrun}, 32'd1);
      repeat (5) tick();
      chk("t5_overrun_sticky", {31'd0, overrun}, 32'd1);

      // Reset during commit cycle 3 aborts the commit at once.
      l0 = load_cnt;
      stage(8'hE0, 10, 1'b1);
      window = 1'b1;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("t6_load_cnt", load_cnt - l0, 32'd3);
      chk("t6_mem_load", {31'd0, mem_load}, 32'd0);
      chk("t6_mem_shift", {31'd0, mem_shift}, 32'd0);
      chk("t6_mem_own", {31'd0, mem_own}, 32'd0);
      chk("t6_mem_instr", {24'd0, mem_instr}, 32'd0);
      chk("t6_wr_ready", {31'd0, wr_ready}, 32'd1);
      chk("t6_pending", {31'd0, pending}, 32'd0);
      chk("t6_overrun_cleared", {31'd0, overrun}, 32'd0);
      exp_q.delete();
      window = 1'b0;
      repeat (3) tick();
      chk("t6_no_more_loads", load_cnt - l0, 32'd3);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
